// File: rtl/mem_dump_engine_pkg.sv
// mem_dump_engine_pkg: FSM state encoding and word size shared by the dump engine (SUM state only with DUMP_CHECKSUM_EN)
package mem_dump_engine_pkg;
    localparam int WORD_BYTES = 4;
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
`ifdef DUMP_CHECKSUM_EN
        , SUM
`endif
    } state_t;
endpackage

// File: rtl/mem_dump_engine.sv
// mem_dump_engine: streams word_count words from a combinational-read memory onto a valid/ready port
// Optional DUMP_CHECKSUM_EN appends a modulo-2^32 sum of all streamed words as a trailing word.
module mem_dump_engine
    import mem_dump_engine_pkg::*;
#(
    parameter int MAX_WORDS = 1024,
    parameter int CNT_W     = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic [31:0]      mem_addr,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);
`ifdef DUMP_CHECKSUM_EN
    localparam state_t LAST = SUM;
    logic [31:0] sum_q;
`else
    localparam state_t LAST = DONE;
`endif
    state_t           state_q, state_d;
    logic [31:0]      addr_q, maddr_q, data_q;
    logic [CNT_W-1:0] cnt_q;
    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end
    // next-state logic; the trailing state is SUM or DONE depending on the build
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (word_count != '0) ? FETCH : LAST;
            FETCH:   state_d = SEND;
            SEND:    if (out_ready) state_d = (cnt_q > CNT_W'(1)) ? FETCH : LAST;
`ifdef DUMP_CHECKSUM_EN
            SUM:     if (out_ready) state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // datapath: latch request, capture fetched word, advance address/count on each transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            maddr_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
`ifdef DUMP_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            if (state_q == IDLE && start) begin
                addr_q <= base_addr & ~32'h3;
                cnt_q  <= (word_count > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : word_count;
`ifdef DUMP_CHECKSUM_EN
                sum_q  <= '0;
`endif
            end
            if (state_q == FETCH) begin
                data_q  <= mem_rdata;
                maddr_q <= addr_q;
            end
            if (state_q == SEND && out_ready) begin
                addr_q <= addr_q + 32'(WORD_BYTES);
                cnt_q  <= cnt_q - CNT_W'(1);
`ifdef DUMP_CHECKSUM_EN
                sum_q  <= sum_q + data_q;
`endif
            end
        end
    end
    // outputs decoded from state; mem_addr holds the last fetched address outside FETCH
    always_comb begin
        busy     = state_q != IDLE;
        done     = state_q == DONE;
        mem_addr = (state_q == FETCH) ? addr_q : maddr_q;
`ifdef DUMP_CHECKSUM_EN
        out_valid = (state_q == SEND) || (state_q == SUM);
        out_data  = (state_q == SUM) ? sum_q : data_q;
`else
        out_valid = state_q == SEND;
        out_data  = data_q;
`endif
    end
endmodule

// File: tb/tb_mem_dump_engine.sv
// tb_mem_dump_engine: randomized self-checking bench comparing the stream against a word-list model
module tb_mem_dump_engine;
    logic        clk = 1'b0;
    logic        reset, start, out_valid, out_ready, busy, done;
    logic [31:0] base_addr, mem_addr, mem_rdata, out_data;
    logic [10:0] word_count;
    logic [31:0] mem [16];
    int          checks = 0, errors = 0, cyc = 0, done_n = 0, done_cyc = 0;
    logic [31:0] got[$], addrs[$];
    int          gcyc[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
`ifdef DUMP_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    mem_dump_engine dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign mem_rdata = mem[mem_addr[5:2]];

    task automatic chk(input string tag, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, g, e);
        end
    endtask

    // observe stream, fetch addresses (busy, not valid, not done) and done pulses
    always @(negedge clk) begin
        if (prev_stall && out_valid) chk("hold", out_data, prev_data);
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (out_valid && out_ready) begin
            got.push_back(out_data);
            gcyc.push_back(cyc);
        end
        if (busy && !out_valid && !done) addrs.push_back(mem_addr);
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    // mode 0: ready held high, 1: random ready plus stray starts, 2: stall second word 5 cycles
    task automatic dump(input logic [31:0] base, input int n, input int mode);
        logic [31:0] exp[$], eaddr[$];
        logic [31:0] a, s;
        int c0, stall;
        a = base & ~32'h3;
        s = '0;
        for (int i = 0; i < n; i++) begin
            exp.push_back(mem[a[5:2]]);
            eaddr.push_back(a);
            s += mem[a[5:2]];
            a += 32'd4;
        end
        if (CK == 1) exp.push_back(s);
        got.delete(); gcyc.delete(); addrs.delete();
        done_n = 0;
        stall  = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; word_count = 11'(n); out_ready = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; base_addr = $urandom; word_count = 11'($urandom);
        for (int k = 0; k < 4000 && done_n == 0; k++) begin
            if (mode == 1) begin
                out_ready = 1'($urandom_range(0, 1));
                start     = 1'($urandom_range(0, 1));
            end else if (mode == 2 && out_valid && got.size() == 1 && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else out_ready = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("done_seen", 32'(done_n > 0), 32'd1);
        chk("words", 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk("word", got[i], exp[i]);
        chk("naddr", 32'(addrs.size()), 32'(n));
        for (int i = 0; i < eaddr.size() && i < addrs.size(); i++) chk("addr", addrs[i], eaddr[i]);
        if (mode == 0) begin
            chk("latency", 32'(done_cyc - c0), 32'(2 * n + 1 + CK));
            for (int i = 1; i < gcyc.size(); i++) chk("gap", 32'(gcyc[i] - gcyc[i-1]), 32'd2);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("done_once", 32'(done_n), 32'd1);
        chk("idle", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        reset = 1'b0;
        dump(32'h0, 4, 0);
        dump(32'h0, 4, 2);
        dump(32'h7, 1, 0);
        dump(32'hFFFF_FFFC, 2, 0);
        dump(32'h0, 0, 0);
        // abort during the third word of an 8-word dump
        got.delete();
        done_n = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = '0; word_count = 11'd8; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 100 && !(out_valid && got.size() == 2); k++) begin
            @(posedge clk); #1;
        end
        chk("abort_at", 32'(got.size()), 32'd2);
        reset = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_data", out_data, 32'd0);
        reset = 1'b0; out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_done", 32'(done_n), 32'd0);
        chk("abort_words", 32'(got.size()), 32'd2);
        dump(32'h0, 3, 0);
`ifdef DUMP_CHECKSUM_EN
        mem[0] = 32'hFFFF_FFFF; mem[1] = 32'h2;
        dump(32'h0, 2, 0);
        chk("sum_wrap", (got.size() == 3) ? got[2] : 32'hDEAD_BEEF, 32'h1);
`endif
        repeat (10) dump($urandom, $urandom_range(0, 12), $urandom_range(0, 2));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
